// File: rtl/vend_change.sv
// rtl/vend_change.sv - coin-credit vending controller with synchronised sensors, vend pulse and nickel change return
// Registered Moore outputs are loaded from the next-state decode, so they change on the same edge as the state.
module vend_change #(
    parameter int WIDTH = 8,
    parameter int PRICE = 30,
    parameter int NVAL  = 5,
    parameter int DVAL  = 10,
    parameter int QVAL  = 25
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_n,
    input  logic             i_d,
    input  logic             i_q,
    input  logic             i_cancel,
    input  logic             i_change_ack,
    output logic [WIDTH-1:0] o_credit,
    output logic             o_vend,
    output logic             o_change_n,
    output logic             o_reject,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] L_PRICE = WIDTH'(PRICE);
    localparam logic [WIDTH-1:0] L_NVAL  = WIDTH'(NVAL);
    localparam logic [WIDTH-1:0] L_DVAL  = WIDTH'(DVAL);
    localparam logic [WIDTH-1:0] L_QVAL  = WIDTH'(QVAL);

    typedef enum logic [1:0] {
        S_ACCUM  = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_credit;
    logic             r_vend;
    logic             r_change_n;
    logic             r_reject;
    logic             r_busy;

    // Sensor bits are ordered {q, d, n}; stage 3 only serves the rising-edge detect.
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_sync3;

    logic [2:0]       w_evt;
    logic             w_take;
    logic             w_dup;
    logic [WIDTH-1:0] w_val;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_left;
    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_credit;
    logic             w_next_reject;

    assign w_evt  = r_sync2 & ~r_sync3;
    assign w_sum  = {1'b0, r_credit} + {1'b0, w_val};
    assign w_left = r_credit - L_PRICE;

    always_comb begin
        w_take = 1'b0;
        w_dup  = 1'b0;
        w_val  = '0;
        if (w_evt[2]) begin
            w_take = 1'b1;
            w_val  = L_QVAL;
            w_dup  = w_evt[1] | w_evt[0];
        end else if (w_evt[1]) begin
            w_take = 1'b1;
            w_val  = L_DVAL;
            w_dup  = w_evt[0];
        end else if (w_evt[0]) begin
            w_take = 1'b1;
            w_val  = L_NVAL;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_credit = r_credit;
        w_next_reject = 1'b0;
        case (r_state)
            S_ACCUM: begin
                if (w_take) begin
                    if (w_sum[WIDTH]) begin
                        w_next_reject = 1'b1;
                    end else begin
                        w_next_credit = w_sum[WIDTH-1:0];
                    end
                    if (w_dup) begin
                        w_next_reject = 1'b1;
                    end
                end
                if (r_credit >= L_PRICE) begin
                    w_next_state = S_VEND;
                end else if (i_cancel && (r_credit != '0)) begin
                    w_next_state = S_CHANGE;
                end
            end
            S_VEND: begin
                w_next_reject = |w_evt;
                w_next_credit = w_left;
                w_next_state  = (w_left != '0) ? S_CHANGE : S_ACCUM;
            end
            S_CHANGE: begin
                w_next_reject = |w_evt;
                if (r_credit == '0) begin
                    w_next_state = S_ACCUM;
                end else if (i_change_ack) begin
                    w_next_credit = r_credit - L_NVAL;
                    if (r_credit == L_NVAL) begin
                        w_next_state = S_ACCUM;
                    end
                end
            end
            default: begin
                w_next_state = S_ACCUM;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= S_ACCUM;
            r_credit   <= '0;
            r_vend     <= 1'b0;
            r_change_n <= 1'b0;
            r_reject   <= 1'b0;
            r_busy     <= 1'b0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync3    <= '0;
        end else begin
            r_sync1    <= {i_q, i_d, i_n};
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_state    <= w_next_state;
            r_credit   <= w_next_credit;
            r_reject   <= w_next_reject;
            r_vend     <= (w_next_state == S_VEND);
            r_change_n <= (w_next_state == S_CHANGE);
            r_busy     <= (w_next_state == S_VEND) || (w_next_state == S_CHANGE);
        end
    end

    assign o_credit   = r_credit;
    assign o_vend     = r_vend;
    assign o_change_n = r_change_n;
    assign o_reject   = r_reject;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_vend_change.sv
// tb/tb_vend_change.sv - directed vector bench for vend_change (default build plus a 6-bit, price-60 build)
module tb_vend_change;

    logic       clk;
    logic       rst_n;
    logic       n1, d1, q1, cancel1, ack1;
    logic [7:0] credit1;
    logic       vend1, chg1, rej1, busy1;
    logic       n2, d2, q2, cancel2, ack2;
    logic [5:0] credit2;
    logic       vend2, chg2, rej2, busy2;

    int n_checks;
    int n_errors;

    vend_change u_dut (
        .i_clock(clk), .i_resetn(rst_n), .i_n(n1), .i_d(d1), .i_q(q1),
        .i_cancel(cancel1), .i_change_ack(ack1), .o_credit(credit1),
        .o_vend(vend1), .o_change_n(chg1), .o_reject(rej1), .o_busy(busy1)
    );

    vend_change #(.WIDTH(6), .PRICE(60)) u_dut6 (
        .i_clock(clk), .i_resetn(rst_n), .i_n(n2), .i_d(d2), .i_q(q2),
        .i_cancel(cancel2), .i_change_ack(ack2), .o_credit(credit2),
        .o_vend(vend2), .o_change_n(chg2), .o_reject(rej2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic n, d, q, c, a;
        int   credit;
        logic vend, chg, rej, busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic n, input logic d, input logic q, input logic c, input logic a,
                       input int credit, input logic v, input logic ch, input logic rj, input logic b);
        vec_t e;
        e.n = n; e.d = d; e.q = q; e.c = c; e.a = a;
        e.credit = credit; e.vend = v; e.chg = ch; e.rej = rj; e.busy = b;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coin(input int ch, input logic val);
        case (ch)
            0: n1 = val;
            1: d1 = val;
            2: q1 = val;
            3: n2 = val;
            4: d2 = val;
            default: q2 = val;
        endcase
    endtask

    // Sensor high for two cycles; the credit update and any reject are visible after the third edge.
    task automatic coin(input int ch, output logic rej_seen);
        set_coin(ch, 1'b1);
        tick();
        tick();
        set_coin(ch, 1'b0);
        tick();
        rej_seen = (ch < 3) ? rej1 : rej2;
    endtask

    initial begin
        logic r;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        {n1, d1, q1, cancel1, ack1} = '0;
        {n2, d2, q2, cancel2, ack2} = '0;

        //      n d q c a  credit  vend chg rej busy
        add(1,0,0,0,0,  0, 0,0,0,0);
        add(1,0,0,0,0,  0, 0,0,0,0);
        add(0,0,0,0,0,  5, 0,0,0,0);
        add(0,0,0,0,0,  5, 0,0,0,0);
        add(0,1,0,0,0,  5, 0,0,0,0);
        add(0,1,0,0,0,  5, 0,0,0,0);
        add(0,0,0,0,0, 15, 0,0,0,0);
        add(0,0,1,0,0, 15, 0,0,0,0);
        add(0,0,1,0,0, 15, 0,0,0,0);
        add(0,0,0,0,0, 40, 0,0,0,0);
        add(0,0,0,0,0, 40, 1,0,0,1);
        add(0,0,0,0,0, 10, 0,1,0,1);
        add(0,0,0,0,0, 10, 0,1,0,1);
        add(0,0,0,0,1,  5, 0,1,0,1);
        add(0,0,0,0,1,  0, 0,0,0,0);
        add(0,0,0,0,1,  0, 0,0,0,0);
        add(0,1,0,0,0,  0, 0,0,0,0);
        add(0,1,0,0,0,  0, 0,0,0,0);
        add(0,0,0,0,0, 10, 0,0,0,0);
        add(0,0,0,1,0, 10, 0,1,0,1);
        add(0,0,0,0,1,  5, 0,1,0,1);
        add(0,0,0,0,1,  0, 0,0,0,0);
        add(1,0,1,0,0,  0, 0,0,0,0);
        add(1,0,1,0,0,  0, 0,0,0,0);
        add(0,0,0,0,0, 25, 0,0,1,0);
        add(0,0,0,0,0, 25, 0,0,0,0);
        add(0,0,1,0,0, 25, 0,0,0,0);
        add(0,0,1,0,0, 25, 0,0,0,0);
        add(0,0,0,0,0, 50, 0,0,0,0);
        add(0,1,0,0,0, 50, 1,0,0,1);
        add(0,1,0,0,0, 20, 0,1,0,1);
        add(0,0,0,0,0, 20, 0,1,1,1);
        add(0,0,0,0,1, 15, 0,1,0,1);
        add(0,0,0,0,1, 10, 0,1,0,1);
        add(0,0,0,0,1,  5, 0,1,0,1);
        add(0,0,0,0,1,  0, 0,0,0,0);
        add(0,0,0,1,0,  0, 0,0,0,0);

        tick();
        tick();
        chk("reset credit", int'(credit1), 0);
        chk("reset flags", int'({vend1, chg1, rej1, busy1}), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            n1 = tbl[i].n; d1 = tbl[i].d; q1 = tbl[i].q;
            cancel1 = tbl[i].c; ack1 = tbl[i].a;
            tick();
            chk($sformatf("vec%0d credit", i), int'(credit1), tbl[i].credit);
            chk($sformatf("vec%0d vend/chg/rej/busy", i), int'({vend1, chg1, rej1, busy1}),
                int'({tbl[i].vend, tbl[i].chg, tbl[i].rej, tbl[i].busy}));
        end
        {n1, d1, q1, cancel1, ack1} = '0;

        // Stall in CHANGE with no acknowledge, then reset asynchronously mid-cycle.
        coin(1, r);
        chk("stall setup credit", int'(credit1), 10);
        cancel1 = 1'b1;
        tick();
        cancel1 = 1'b0;
        chk("stall enter change", int'({chg1, busy1}), 3);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("stall%0d chg/credit", k), int'({chg1, credit1}), int'({1'b1, 8'd10}));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset credit", int'(credit1), 0);
        chk("async reset flags", int'({vend1, chg1, rej1, busy1}), 0);
        #2;
        rst_n = 1'b1;
        coin(0, r);
        chk("post-reset nickel credit", int'(credit1), 5);
        chk("post-reset nickel reject", int'(r), 0);

        // Narrow build: overflow rejection at 50 + 25 > 63, then exact vend at 60.
        coin(5, r);
        chk("w6 q1 credit", int'(credit2), 25);
        coin(5, r);
        chk("w6 q2 credit", int'(credit2), 50);
        coin(5, r);
        chk("w6 overflow credit", int'(credit2), 50);
        chk("w6 overflow reject", int'(r), 1);
        tick();
        chk("w6 reject one cycle", int'(rej2), 0);
        coin(4, r);
        chk("w6 d credit", int'(credit2), 60);
        tick();
        chk("w6 vend flags", int'({vend2, chg2, busy2}), 5);
        tick();
        chk("w6 after vend credit", int'(credit2), 0);
        chk("w6 after vend flags", int'({vend2, chg2, busy2}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
